// File: rtl/serial_bound_reducer_if.sv
// Candidate and result channels of the serial bound reducer.
// slave = reducer side, master = producer/consumer side.
interface serial_bound_reducer_if #(
  parameter int NUMBER_SIZE = 4,
  parameter int COUNT_SIZE  = 4
);
  logic                          start;
  logic                          cand_valid;
  logic                          cand_ready;
  logic signed [NUMBER_SIZE-1:0] cand_number;
  logic                          cand_activation;
  logic                          cand_is_upper;
  logic                          cand_last;
  logic                          result_valid;
  logic                          result_ready;
  logic signed [NUMBER_SIZE-1:0] lower_bound;
  logic                          lower_active;
  logic signed [NUMBER_SIZE-1:0] upper_bound;
  logic                          upper_active;
  logic                          feasible;
  logic [COUNT_SIZE-1:0]         cand_count;

  modport slave (
    input  start, cand_valid, cand_number,
    input  cand_activation, cand_is_upper,
    input  cand_last, result_ready,
    output cand_ready, result_valid,
    output lower_bound, lower_active,
    output upper_bound, upper_active,
    output feasible, cand_count
  );

  modport master (
    output start, cand_valid, cand_number,
    output cand_activation, cand_is_upper,
    output cand_last, result_ready,
    input  cand_ready, result_valid,
    input  lower_bound, lower_active,
    input  upper_bound, upper_active,
    input  feasible, cand_count
  );
endinterface

// File: rtl/serial_bound_reducer.sv
// Serial reducer: folds (value, activation) bound candidates
// into a [max lower, min upper] interval with feasibility flag.
module serial_bound_reducer #(
  parameter int NUMBER_SIZE = 4,
  parameter int COUNT_SIZE  = 4
) (
  input logic clk,
  input logic rst_n,
  serial_bound_reducer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic ready;
  logic hs;

  logic signed [NUMBER_SIZE-1:0] lb;
  logic signed [NUMBER_SIZE-1:0] ub;
  logic                          la;
  logic                          ua;
  logic [COUNT_SIZE-1:0]         cnt;

  assign hs = bus.cand_valid & ready;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nx = ACCUM;
      end
      ACCUM: begin
        ready = ~bus.start;
        if (hs && bus.cand_last) state_nx = DONE;
      end
      DONE: begin
        if (bus.result_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // start always reopens a frame, aborting any frame in flight
    if (bus.start) state_nx = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb  <= '0;
      ub  <= '0;
      la  <= 1'b0;
      ua  <= 1'b0;
      cnt <= '0;
    end else if (bus.start) begin
      lb  <= '0;
      ub  <= '0;
      la  <= 1'b0;
      ua  <= 1'b0;
      cnt <= '0;
    end else if (hs) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
      if (bus.cand_activation) begin
        if (bus.cand_is_upper) begin
          if (!ua || bus.cand_number < ub)
            ub <= bus.cand_number;
          ua <= 1'b1;
        end else begin
          if (!la || bus.cand_number > lb)
            lb <= bus.cand_number;
          la <= 1'b1;
        end
      end
    end
  end

  assign bus.cand_ready   = ready;
  assign bus.result_valid = (state == DONE);
  assign bus.lower_bound  = lb;
  assign bus.lower_active = la;
  assign bus.upper_bound  = ub;
  assign bus.upper_active = ua;
  assign bus.cand_count   = cnt;
  assign bus.feasible     = ~(la & ua) | (lb <= ub);

endmodule

// File: tb/tb_serial_bound_reducer.sv
// Scoreboard bench for serial_bound_reducer: directed frames,
// expected results queued by stimulus, checked by a monitor.
module tb_serial_bound_reducer;

  localparam int NS = 4;
  localparam int CS = 4;

  typedef struct packed {
    logic signed [NS-1:0] lb;
    logic                 la;
    logic signed [NS-1:0] ub;
    logic                 ua;
    logic                 feas;
    logic [CS-1:0]        cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sb[$];

  serial_bound_reducer_if #(.NUMBER_SIZE(NS), .COUNT_SIZE(CS)) bus ();

  serial_bound_reducer #(
    .NUMBER_SIZE(NS),
    .COUNT_SIZE (CS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: compare every accepted result against the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.result_valid && bus.result_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sb_empty: got result, want none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_la", int'(bus.lower_active), int'(e.la));
        chk("res_ua", int'(bus.upper_active), int'(e.ua));
        if (e.la) chk("res_lb", int'(bus.lower_bound), int'(e.lb));
        if (e.ua) chk("res_ub", int'(bus.upper_bound), int'(e.ub));
        chk("res_feas", int'(bus.feasible), int'(e.feas));
        chk("res_cnt", int'(bus.cand_count), int'(e.cnt));
      end
    end
  end

  function automatic exp_t mk(input int lb, input int la,
                              input int ub, input int ua,
                              input int feas, input int cnt);
    exp_t e;
    e.lb   = NS'(lb);
    e.la   = 1'(la);
    e.ub   = NS'(ub);
    e.ua   = 1'(ua);
    e.feas = 1'(feas);
    e.cnt  = CS'(cnt);
    return e;
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input int v, input bit act,
                      input bit up, input bit last);
    bit done;
    done = 1'b0;
    bus.cand_valid      = 1'b1;
    bus.cand_number     = NS'(v);
    bus.cand_activation = act;
    bus.cand_is_upper   = up;
    bus.cand_last       = last;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = bus.cand_ready;
      @(posedge clk); #1;
    end
    bus.cand_valid = 1'b0;
    bus.cand_last  = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_result(input bit take);
    bit seen;
    seen = 1'b0;
    bus.result_ready = take;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = bus.result_valid;
      @(posedge clk); #1;
    end
    bus.result_ready = 1'b0;
    if (!seen) chk("result_timeout", 0, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cand_valid = 1'b0;
    bus.cand_number = '0;
    bus.cand_activation = 1'b0;
    bus.cand_is_upper = 1'b0;
    bus.cand_last = 1'b0;
    bus.result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset mid-frame
    pulse_start();
    send(3, 1, 0, 0);
    send(2, 1, 1, 0);
    rst_n = 1'b0;
    #2;
    chk("rst_ready", int'(bus.cand_ready), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_la", int'(bus.lower_active), 0);
    chk("rst_ua", int'(bus.upper_active), 0);
    chk("rst_feas", int'(bus.feasible), 1);
    chk("rst_cnt", int'(bus.cand_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", int'(bus.cand_ready), 0);

    // 2: mixed active lower/upper
    sb.push_back(mk(2, 1, 3, 1, 1, 6));
    pulse_start();
    send(-3, 1, 0, 0);
    send(2, 1, 0, 0);
    send(1, 1, 0, 0);
    send(5, 1, 1, 0);
    send(3, 1, 1, 0);
    send(7, 1, 1, 1);
    wait_result(1);

    // 3: infeasible, inactive upper ignored
    sb.push_back(mk(4, 1, 1, 1, 0, 3));
    pulse_start();
    send(4, 1, 0, 0);
    send(1, 1, 1, 0);
    send(-8, 0, 1, 1);
    wait_result(1);

    // 4: nothing active
    sb.push_back(mk(0, 0, 0, 0, 1, 3));
    pulse_start();
    send(5, 0, 0, 0);
    send(-2, 0, 1, 0);
    send(1, 0, 0, 1);
    wait_result(1);

    // extremes, equal bounds still feasible
    sb.push_back(mk(7, 1, 7, 1, 1, 3));
    pulse_start();
    send(-8, 1, 0, 0);
    send(7, 1, 1, 0);
    send(7, 1, 0, 1);
    wait_result(1);

    // 5: abort with concurrent candidate
    pulse_start();
    send(2, 1, 0, 0);
    bus.start = 1'b1;
    bus.cand_valid = 1'b1;
    bus.cand_number = NS'(-5);
    bus.cand_activation = 1'b1;
    bus.cand_is_upper = 1'b1;
    bus.cand_last = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(bus.cand_ready), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cand_valid = 1'b0;
    bus.cand_last = 1'b0;
    @(negedge clk);
    chk("abort_cnt", int'(bus.cand_count), 0);
    chk("abort_ua", int'(bus.upper_active), 0);
    chk("abort_rv", int'(bus.result_valid), 0);
    @(posedge clk); #1;
    sb.push_back(mk(-1, 1, -1, 1, 1, 2));
    send(-1, 1, 0, 0);
    send(-1, 1, 1, 1);
    wait_result(1);

    // 6: 20 candidates, saturating count, backpressure
    sb.push_back(mk(5, 1, -2, 1, 0, 15));
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) send(i / 2 - 4, 1, 0, 0);
      else            send(7 - i / 2, 1, 1, i == 19);
    end
    bus.result_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.result_valid), 1);
      chk("bp_ready", int'(bus.cand_ready), 0);
      chk("bp_lb", int'(bus.lower_bound), 5);
      chk("bp_ub", int'(bus.upper_bound), -2);
      chk("bp_cnt", int'(bus.cand_count), 15);
      @(posedge clk); #1;
    end
    wait_result(1);
    @(negedge clk);
    chk("post_valid", int'(bus.result_valid), 0);
    chk("post_lb", int'(bus.lower_bound), 5);
    chk("post_cnt", int'(bus.cand_count), 15);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
